// File: rtl/b16_memctl_pkg.sv
// Shared codes for the b16 memory controller: FSM states, sequencer states, region codes
// and default geometry.
package b16_memctl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BOOT = 2'd1;
    localparam logic [1:0] ST_IO   = 2'd2;
    localparam logic [1:0] ST_SRAM = 2'd3;

    localparam logic [1:0] SS_IDLE   = 2'd0;
    localparam logic [1:0] SS_SETUP  = 2'd1;
    localparam logic [1:0] SS_STROBE = 2'd2;
    localparam logic [1:0] SS_HOLD   = 2'd3;

    localparam logic [1:0] R_IO   = 2'd0;
    localparam logic [1:0] R_BOOT = 2'd1;
    localparam logic [1:0] R_SRAM = 2'd2;

    localparam int unsigned DEF_AW      = 16;
    localparam int unsigned DEF_DW      = 16;
    localparam int unsigned DEF_BOOT_AW = 12;
    localparam int unsigned DEF_SRAM_WS = 3;
    localparam int unsigned DEF_SRAM_AW = 18;

    function automatic logic [1:0] state_for(input logic [1:0] region);
        case (region)
            R_IO:    return ST_IO;
            R_BOOT:  return ST_BOOT;
            default: return ST_SRAM;
        endcase
    endfunction

endpackage

// File: rtl/b16_memctl_sram_if.sv
// External async SRAM sequencer: setup, SRAM_WS+1 strobe cycles, hold. Pins decode
// straight from the state register so an async reset releases them at once.
module b16_memctl_sram_if
    import b16_memctl_pkg::*;
#(
    parameter int unsigned DW      = 16,
    parameter int unsigned SRAM_AW = 18,
    parameter int unsigned SRAM_WS = 3
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               start,
    input  logic               write,
    input  logic [1:0]         lanes,
    input  logic [SRAM_AW-1:0] addr,
    input  logic [DW-1:0]      wdata,
    output logic               capture,
    output logic               done,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DW-1:0]      sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam logic [2:0] LAST = 3'(SRAM_WS);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       active, strobe, last;

    assign active = state_q != SS_IDLE;
    assign strobe = state_q == SS_STROBE;
    assign last   = cnt_q == LAST;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SS_IDLE:   if (start) state_d = SS_SETUP;
            SS_SETUP: begin
                state_d = SS_STROBE;
                cnt_d   = '0;
            end
            SS_STROBE: begin
                if (last) state_d = SS_HOLD;
                else      cnt_d   = cnt_q + 3'd1;
            end
            default:   state_d = SS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= SS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reads drive both lanes; writes only the requested ones.
    assign sram_ce_n  = ~active;
    assign sram_oe_n  = ~(strobe & ~write);
    assign sram_we_n  = ~(strobe & write);
    assign sram_ub_n  = ~(active & (~write | lanes[1]));
    assign sram_lb_n  = ~(active & (~write | lanes[0]));
    assign sram_dq_oe = active & write;
    assign sram_addr  = addr;
    assign sram_dq_o  = wdata;
    assign capture    = strobe & last & ~write;
    assign done       = state_q == SS_HOLD;

endmodule

// File: rtl/b16_memctl.sv
// b16 memory controller: arbitrates cpu/debugger, decodes IO page, boot RAM and external
// SRAM, and returns a one-cycle ready pulse to the granted master.
module b16_memctl
    import b16_memctl_pkg::*;
#(
    parameter int unsigned    AW        = DEF_AW,
    parameter int unsigned    DW        = DEF_DW,
    parameter int unsigned    BOOT_AW   = DEF_BOOT_AW,
    parameter logic [AW-1:0]  BOOT_BASE = 16'h2000,
    parameter logic [AW-1:0]  IO_BASE   = 16'hFFFC,
    parameter int unsigned    SRAM_WS   = DEF_SRAM_WS,
    parameter int unsigned    SRAM_AW   = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [AW-1:0]      c_addr,
    input  logic               c_r,
    input  logic [1:0]         c_w,
    input  logic [DW-1:0]      c_wdata,
    output logic [DW-1:0]      c_rdata,
    output logic               c_ready,
    input  logic [AW-1:0]      d_addr,
    input  logic               d_r,
    input  logic [1:0]         d_w,
    input  logic [DW-1:0]      d_wdata,
    output logic [DW-1:0]      d_rdata,
    output logic               d_ready,
    output logic               io_sel,
    output logic [1:0]         io_addr,
    output logic               io_r,
    output logic [1:0]         io_w,
    output logic [DW-1:0]      io_wdata,
    input  logic [DW-1:0]      io_rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [DW-1:0]      sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [DW-1:0]      sram_dq_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n,
    output logic               busy
);

    logic [1:0]      state_q, state_d;
    logic            gnt_q;
    logic [AW-1:1]   addr_q;
    logic            rd_q;
    logic [1:0]      w_q;
    logic [DW-1:0]   wdata_q;

    logic            c_req, d_req, c_elig, d_elig, accept, pick_d, pick_r;
    logic [AW-1:0]   pick_addr;
    logic [1:0]      pick_w, region;
    logic            sram_cap, sram_done, fin, gnt_req, cap_en;
    logic [DW-1:0]   cap_data;
    logic [BOOT_AW-1:0] boot_idx;

    logic [7:0] boot_lo [0:(1<<BOOT_AW)-1];
    logic [7:0] boot_hi [0:(1<<BOOT_AW)-1];

    assign c_req  = c_r | (|c_w);
    assign d_req  = d_r | (|d_w);
    // A master still held high during its own ready pulse must not be re-accepted.
    assign c_elig = c_req & ~c_ready;
    assign d_elig = d_req & ~d_ready;
    assign pick_d = d_elig;
    assign pick_addr = pick_d ? d_addr : c_addr;
    assign pick_r    = pick_d ? d_r : c_r;
    assign pick_w    = pick_d ? d_w : c_w;
    assign accept    = (state_q == ST_IDLE) & (c_elig | d_elig);

    always_comb begin
        if (pick_addr[AW-1:2] == IO_BASE[AW-1:2])                     region = R_IO;
        else if (pick_addr[AW-1:BOOT_AW+1] == BOOT_BASE[AW-1:BOOT_AW+1]) region = R_BOOT;
        else                                                            region = R_SRAM;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = state_for(region);
            ST_SRAM: if (sram_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign fin      = (state_q == ST_BOOT) | (state_q == ST_IO) |
                      ((state_q == ST_SRAM) & sram_done);
    assign gnt_req  = gnt_q ? d_req : c_req;
    assign boot_idx = addr_q[BOOT_AW:1];

    always_comb begin
        cap_en   = 1'b0;
        cap_data = '0;
        if ((state_q == ST_BOOT) && rd_q) begin
            cap_en   = 1'b1;
            cap_data = {boot_hi[boot_idx], boot_lo[boot_idx]};
        end else if ((state_q == ST_IO) && rd_q) begin
            cap_en   = 1'b1;
            cap_data = io_rdata;
        end else if (sram_cap) begin
            cap_en   = 1'b1;
            cap_data = sram_dq_i;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            w_q     <= '0;
            wdata_q <= '0;
            c_ready <= 1'b0;
            d_ready <= 1'b0;
            c_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_q   <= pick_d;
                addr_q  <= pick_addr[AW-1:1];
                rd_q    <= pick_r;
                w_q     <= pick_r ? 2'b00 : pick_w;
                wdata_q <= pick_d ? d_wdata : c_wdata;
            end
            // Ready is dropped if the granted master abandoned its request.
            c_ready <= fin & ~gnt_q & gnt_req;
            d_ready <= fin & gnt_q & gnt_req;
            if (cap_en && !gnt_q) c_rdata <= cap_data;
            if (cap_en && gnt_q)  d_rdata <= cap_data;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_BOOT) begin
            if (w_q[0]) boot_lo[boot_idx] <= wdata_q[7:0];
            if (w_q[1]) boot_hi[boot_idx] <= wdata_q[15:8];
        end
    end

    assign io_sel   = state_q == ST_IO;
    assign io_addr  = addr_q[2:1];
    assign io_r     = io_sel & rd_q;
    assign io_w     = io_sel ? w_q : 2'b00;
    assign io_wdata = wdata_q;
    assign busy     = state_q != ST_IDLE;

    b16_memctl_sram_if #(
        .DW      (DW),
        .SRAM_AW (SRAM_AW),
        .SRAM_WS (SRAM_WS)
    ) u_sram_if (
        .clk        (clk),
        .nreset     (nreset),
        .start      (accept && (region == R_SRAM)),
        .write      (|w_q),
        .lanes      (w_q),
        .addr       (SRAM_AW'(addr_q)),
        .wdata      (wdata_q),
        .capture    (sram_cap),
        .done       (sram_done),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

endmodule
